// File: rtl/data_memory_ls_pkg.sv
// Shared definitions for the RV32 sized data memory: funct3 access codes
// and the clear/ready state type.
package dmem_pkg;

  // Load/store size and signedness codes, as found in the funct3 field.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Sequencer states: sweeping zeros through the array, or serving the core.
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  // True for the funct3 codes that access a halfword.
  function automatic logic is_half(input logic [2:0] funct3);
    return (funct3 == F3_H) || (funct3 == F3_HU);
  endfunction

  // True for the funct3 code that accesses a full word.
  function automatic logic is_word(input logic [2:0] funct3);
    return funct3 == F3_W;
  endfunction

endpackage

// File: rtl/data_memory_ls_if.sv
// Core-to-data-memory bus. The core (master) supplies the address, the
// access type and store data; the memory (slave) returns load data, the
// ready flag and the alignment-fault flag.
interface data_memory_ls_if;

  logic [31:0] Address;
  logic        WE;
  logic [2:0]  Funct3;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Ready;
  logic        Misaligned;

  modport master (
    output Address, WE, Funct3, WD,
    input  RD, Ready, Misaligned
  );

  modport slave (
    input  Address, WE, Funct3, WD,
    output RD, Ready, Misaligned
  );

endinterface

// File: rtl/data_memory_ls_fmt.sv
// Byte-lane formatter for the data memory. Given the access type, the low
// address bits, store data and the currently stored word, it produces the
// lane write mask, the merged word to write back, the formatted load data
// and the fault flag.
//
// Build option DMEM_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses raise fault, write nothing and load zero. When undefined, the
// offending low address bits are cleared and the access proceeds; fault
// is never raised.
module data_memory_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] rd,
  output logic        fault
);

  logic        half_acc;
  logic        word_acc;
  logic        bad_align;
  logic [1:0]  eff_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic [31:0] load_val;

  // Classify the access and decide the effective byte offset.
  always_comb begin
    half_acc  = is_half(funct3);
    word_acc  = is_word(funct3);
    bad_align = (half_acc && addr_lo[0]) || (word_acc && (addr_lo != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    eff_lo = addr_lo;
    fault  = bad_align;
`else
    // Without trapping, snap the offset down to the access size.
    if (word_acc) begin
      eff_lo = 2'b00;
    end else if (half_acc) begin
      eff_lo = {addr_lo[1], 1'b0};
    end else begin
      eff_lo = addr_lo;
    end
    fault = 1'b0;
`endif
  end

  // Pick the addressed byte and halfword out of the stored word.
  always_comb begin
    unique case (eff_lo)
      2'd0:    ld_byte = raw_word[7:0];
      2'd1:    ld_byte = raw_word[15:8];
      2'd2:    ld_byte = raw_word[23:16];
      default: ld_byte = raw_word[31:24];
    endcase
    ld_half = eff_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Sign- or zero-extend the selected lanes for the load result.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path through the case leaves it unassigned (no latch).
    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
      F3_W:    load_val = raw_word;
      F3_BU:   load_val = {24'h0, ld_byte};
      F3_HU:   load_val = {16'h0, ld_half};
      default: load_val = '0;
    endcase
    rd = fault ? 32'h0 : load_val;
  end

  // Build the lane mask and replicate store data across the lanes.
  always_comb begin
    lane_mask = 4'b0000;
    lane_data = wd;
    case (funct3)
      F3_B: begin
        lane_mask = 4'b0001 << eff_lo;
        lane_data = {4{wd[7:0]}};
      end
      F3_H: begin
        lane_mask = eff_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wd[15:0]}};
      end
      F3_W: begin
        lane_mask = 4'b1111;
        lane_data = wd;
      end
      default: begin
        lane_mask = 4'b0000;
        lane_data = wd;
      end
    endcase
    byte_en = fault ? 4'b0000 : lane_mask;
  end

  // Merge the written lanes into the stored word; untouched lanes keep
  // their current contents.
  always_comb begin
    wdata = raw_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        wdata[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory_ls.sv
// RV32 data memory with sized, lane-aware loads and stores for the
// single-cycle core. Loads are combinational; stores commit on the rising
// edge. After reset a sequencer writes zero to every word, one per cycle,
// and holds Ready low until the sweep is done.
//
// Build option DMEM_MISALIGN_TRAP_EN selects trapping of misaligned
// half/word accesses (see data_memory_fmt); undefined means silent
// alignment.
module data_memory_ls
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  data_memory_ls_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      raw_word;
  logic             ready;

  logic [3:0]       byte_en;
  logic [31:0]      wdata;
  logic [31:0]      fmt_rd;
  logic             fault;
  logic             unused_addr_hi;

  // Addresses wrap modulo the array size; the upper bits are dropped.
  assign word_idx       = bus.Address[IDX_W+1:2];
  assign unused_addr_hi = ^bus.Address[31:IDX_W+2];
  assign raw_word       = mem[word_idx];
  assign ready          = (state == S_READY);

  data_memory_fmt u_fmt (
    .funct3   (bus.Funct3),
    .addr_lo  (bus.Address[1:0]),
    .wd       (bus.WD),
    .raw_word (raw_word),
    .byte_en  (byte_en),
    .wdata    (wdata),
    .rd       (fmt_rd),
    .fault    (fault)
  );

  // Clear sequencer: restart the sweep on reset, step one word per cycle,
  // and enter the ready state on the edge that clears the last word.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesized logic.
    if (rst) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else if (state == S_CLEAR) begin
      clr_idx <= clr_idx + IDX_W'(1);
      if (clr_idx == LAST_IDX) begin
        state <= S_READY;
      end
    end
  end

  // Array write port: zeros from the sweep, or merged store data once ready.
  always_ff @(posedge clk) begin
    // NOTE: the array itself has no reset branch; it is zeroed by the sweep
    // instead, which keeps it mappable onto plain RAM.
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (bus.WE && (byte_en != 4'b0000)) begin
        mem[word_idx] <= wdata;
      end
    end
  end

  // Outputs are held at zero until the sweep has finished.
  assign bus.Ready      = ready;
  assign bus.RD         = ready ? fmt_rd : 32'h0;
  assign bus.Misaligned = ready && fault;

endmodule

// File: tb/tb_data_memory_ls.sv
// Self-checking bench for data_memory_ls. A byte-array reference model
// computes every expected load and fault flag from the load/store rules;
// directed vectors cover the sweep, lanes, extension, alignment, wrap and
// illegal funct3, then random accesses are scored against the model.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_data_memory_ls;

  localparam int DEPTH = 64;
  localparam int BYTES = 4 * DEPTH;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;
  logic [7:0] model_mem [BYTES];

  data_memory_ls_if bus ();

  data_memory_ls #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] a);
    bit half = (f3 == LH) || (f3 == LHU);
    bit word = (f3 == LW);
    return TRAP && ((half && (a % 2 != 0)) || (word && (a % 4 != 0)));
  endfunction

  function automatic int unsigned model_ea(input logic [2:0] f3, input logic [31:0] a);
    int unsigned e = a % BYTES;
    if (!TRAP) begin
      if (f3 == LH || f3 == LHU) e = e - (e % 2);
      else if (f3 == LW)         e = e - (e % 4);
    end
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned e = model_ea(f3, a);
    logic [7:0]  b0;
    logic [15:0] h;
    if (model_fault(f3, a)) return 32'h0;
    b0 = model_mem[e];
    h  = {model_mem[(e + 1) % BYTES], model_mem[e]};
    case (f3)
      LB:      return {{24{b0[7]}}, b0};
      LBU:     return {24'h0, b0};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      LW:      return {model_mem[e + 3], model_mem[e + 2], model_mem[e + 1], model_mem[e]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int unsigned e = model_ea(f3, a);
    if (model_fault(f3, a)) return;
    case (f3)
      LB: model_mem[e] = wd[7:0];
      LH: begin
        model_mem[e]     = wd[7:0];
        model_mem[e + 1] = wd[15:8];
      end
      LW: begin
        model_mem[e]     = wd[7:0];
        model_mem[e + 1] = wd[15:8];
        model_mem[e + 2] = wd[23:16];
        model_mem[e + 3] = wd[31:24];
      end
      default: ;
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
  endtask

  // ---------------- stimulus helpers ----------------
  // One access cycle: outputs are scored mid-cycle against the model's
  // pre-edge contents, then the model takes the store after the edge.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic we, input logic [31:0] wd);
    bus.Funct3  = f3;
    bus.Address = a;
    bus.WE      = we;
    bus.WD      = wd;
    #2;
    check({tag, ".rd"}, bus.RD, model_load(f3, a));
    check({tag, ".mis"}, {31'h0, bus.Misaligned}, {31'h0, model_fault(f3, a)});
    @(posedge clk); #1;
    if (we) model_store(f3, a, wd);
    bus.WE = 1'b0;
  endtask

  // Load with a fixed expected value.
  task automatic expect_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp);
    bus.Funct3  = f3;
    bus.Address = a;
    bus.WE      = 1'b0;
    #2;
    check(tag, bus.RD, exp);
    @(posedge clk); #1;
  endtask

  // Count edges until Ready rises, bounded.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.Ready !== 1'b1 && cycles < 4 * DEPTH) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.Address = 32'h0;
    bus.WE      = 1'b0;
    bus.Funct3  = LW;
    bus.WD      = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {31'h0, bus.Ready}, 32'h0);
    check("rst.rd", bus.RD, 32'h0);
    check("rst.mis", {31'h0, bus.Misaligned}, 32'h0);
    rst = 1'b0;
    wait_ready(cyc);
    check("sweep1.cycles", cyc, DEPTH);
    model_clear();
    for (int w = 0; w < DEPTH; w++) do_op("zero", LW, 32'(4 * w), 1'b0, 32'h0);

    // Byte and half lanes.
    do_op("sw10", LW, 32'h10, 1'b1, 32'h1122_3344);
    do_op("sb12", LB, 32'h12, 1'b1, 32'h0000_00AA);
    expect_load("lanes.sb", LW, 32'h10, 32'h11AA_3344);
    do_op("sh10", LH, 32'h10, 1'b1, 32'h0000_BEEF);
    expect_load("lanes.sh", LW, 32'h10, 32'h11AA_BEEF);

    // Sign and zero extension (also read-during-write returns old data).
    do_op("sw20", LW, 32'h20, 1'b1, 32'h80F0_7F01);
    expect_load("ext.lb",  LB,  32'h22, 32'hFFFF_FFF0);
    expect_load("ext.lbu", LBU, 32'h22, 32'h0000_00F0);
    expect_load("ext.lh",  LH,  32'h22, 32'hFFFF_80F0);
    expect_load("ext.lhu", LHU, 32'h22, 32'h0000_80F0);
    expect_load("ext.lb1", LB,  32'h21, 32'h0000_007F);

    // Misaligned word store at 0x0E.
    do_op("sw0c", LW, 32'h0C, 1'b1, 32'hCAFE_0003);
    bus.Funct3 = LW; bus.Address = 32'h0E; bus.WE = 1'b1; bus.WD = 32'h55;
    #2;
    check("mis.flag", {31'h0, bus.Misaligned}, TRAP ? 32'h1 : 32'h0);
    @(posedge clk); #1;
    bus.WE = 1'b0;
    model_store(LW, 32'h0E, 32'h55);
    expect_load("mis.word3", LW, 32'h0C, TRAP ? 32'hCAFE_0003 : 32'h0000_0055);

    // Address wrap and illegal funct3.
    do_op("wrap", LW, 32'(BYTES + 4), 1'b1, 32'h12);
    expect_load("wrap.lw4", LW, 32'h4, 32'h12);
    do_op("ill.st", 3'b011, 32'h10, 1'b1, 32'hFFFF_FFFF);
    expect_load("ill.rd", 3'b011, 32'h10, 32'h0);
    expect_load("ill.keep", LW, 32'h10, 32'h11AA_BEEF);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      do_op("rnd", 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), $urandom);
    end

    // Mid-sweep restart, outputs forced low, store during clear dropped.
    do_op("sw_fc", LW, 32'hFC, 1'b1, 32'hA5A5_A5A5);
    pulse_rst();
    expect_load("clr.rd", LW, 32'hFC, 32'h0);
    bus.Funct3 = LH; bus.Address = 32'hFD;
    #2;
    check("clr.mis", {31'h0, bus.Misaligned}, 32'h0);
    repeat (28) begin @(posedge clk); #1; end
    check("clr.ready30", {31'h0, bus.Ready}, 32'h0);
    bus.Funct3 = LW; bus.Address = 32'h8; bus.WD = 32'hDEAD_BEEF; bus.WE = 1'b1;
    pulse_rst();
    wait_ready(cyc);
    bus.WE = 1'b0;
    check("sweep2.cycles", cyc, DEPTH);
    model_clear();
    expect_load("clr.drop8", LW, 32'h8, 32'h0);
    expect_load("clr.fc", LW, 32'hFC, 32'h0);

    // Reset from the ready state restarts a full sweep.
    do_op("sw_pre", LW, 32'h40, 1'b1, 32'h1357_9BDF);
    pulse_rst();
    wait_ready(cyc);
    check("sweep3.cycles", cyc, DEPTH);
    model_clear();
    for (int w = 0; w < 8; w++) do_op("zero3", LW, 32'(32 * w), 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
